serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/serial_adder_ripple.sv | 35 +++
 rtl/serial_adder.sv | 168 ++++++++++++++++
 tb/tb_serial_adder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// ----------------------------------------------------------------------------
// serial_adder_pkg
// Shared types and constants for the digit-serial adder/subtractor.
//   state_t  : control FSM states (IDLE, RUN, DONE)
//   MODE_ADD : sub input value selecting A + B + cin
//   MODE_SUB : sub input value selecting A - B
// ----------------------------------------------------------------------------
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_ripple.sv
// ----------------------------------------------------------------------------
// ripple_digit_adder
// Combinational DIGIT-bit ripple adder made of 1-bit full-adder cells.
// Ports:
//   a, b   : DIGIT-bit addend digits
//   cin    : carry into bit 0
//   sum    : DIGIT-bit digit sum
//   cout   : carry out of the digit MSB
//   c_msb  : carry into the digit MSB (used for signed overflow)
// ----------------------------------------------------------------------------
module ripple_digit_adder #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   // c_s[i] is the carry into bit i; c_s[DIGIT] leaves the digit.
   logic [DIGIT:0] c_s;

   assign c_s[0] = cin;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign sum[i]    = a[i] ^ b[i] ^ c_s[i];
      assign c_s[i+1]  = (a[i] & b[i]) | (a[i] & c_s[i]) | (b[i] & c_s[i]);
   end

   assign cout  = c_s[DIGIT];
   assign c_msb = c_s[DIGIT-1];

endmodule : ripple_digit_adder

// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
// Multi-cycle adder/subtractor processing DIGIT bits per clock, LS digit
// first, using one shared ripple_digit_adder slice.
// Ports:
//   clk, rst_n          : rising-edge clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake (accepted only when idle)
//   a, b, cin, sub      : operands; sub=1 computes a - b and ignores cin
//   out_valid/out_ready : result handshake (result held until taken)
//   sum, cout, ovf, zero: result, MSB carry (sub: 1 = no borrow),
//                         signed overflow, result-is-zero flag
// ----------------------------------------------------------------------------
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = $clog2(NDIG) + 1;
   localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

   if (((WIDTH % DIGIT) != 0) || (WIDTH < 2) || (DIGIT < 1)) begin : g_bad_params
      $error("serial_adder: WIDTH must be >= 2 and an exact multiple of DIGIT");
   end

   state_t            state_r;
   state_t            state_next_s;
   logic              capture_s;
   logic              finish_s;

   logic [WIDTH-1:0]  a_r;
   logic [WIDTH-1:0]  b_r;
   logic              carry_r;
   logic [CW-1:0]     cnt_r;
   logic [WIDTH-1:0]  psum_r;

   logic              in_ready_r;
   logic              out_valid_r;
   logic [WIDTH-1:0]  sum_r;
   logic              cout_r;
   logic              ovf_r;
   logic              zero_r;

   logic [DIGIT-1:0]  dsum_s;
   logic              dcout_s;
   logic              dcmsb_s;
   logic [WIDTH-1:0]  psum_next_s;

   ripple_digit_adder #(.DIGIT(DIGIT)) u_digit (
      .a     (a_r[DIGIT-1:0]),
      .b     (b_r[DIGIT-1:0]),
      .cin   (carry_r),
      .sum   (dsum_s),
      .cout  (dcout_s),
      .c_msb (dcmsb_s)
   );

   // New digit enters at the top so after NDIG shifts the LS digit sits at bit 0.
   // Written with shifts so DIGIT == WIDTH needs no separate path.
   assign psum_next_s = (psum_r >> DIGIT) | (WIDTH'(dsum_s) << (WIDTH - DIGIT));

   // Next-state and control strobes for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_next_s = state_r;
      capture_s    = 1'b0;
      finish_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               state_next_s = RUN;
               capture_s    = 1'b1;
            end else begin
               state_next_s = IDLE;
            end
         end
         RUN: begin
            if (cnt_r == LAST_DIG) begin
               state_next_s = DONE;
               finish_s     = 1'b1;
            end else begin
               state_next_s = RUN;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = DONE;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State register plus handshake outputs registered from the next state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         in_ready_r  <= (state_next_s == IDLE);
         out_valid_r <= (state_next_s == DONE);
      end
   end

   // Operand shift registers, carry, digit counter and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_r     <= {WIDTH{1'b0}};
         b_r     <= {WIDTH{1'b0}};
         carry_r <= 1'b0;
         cnt_r   <= {CW{1'b0}};
         psum_r  <= {WIDTH{1'b0}};
         sum_r   <= {WIDTH{1'b0}};
         cout_r  <= 1'b0;
         ovf_r   <= 1'b0;
         zero_r  <= 1'b0;
      end else if (capture_s) begin
         // Subtraction is A + ~B + 1: invert B once here, force carry-in to 1.
         a_r     <= a;
         b_r     <= (sub == MODE_SUB) ? ~b : b;
         carry_r <= (sub == MODE_SUB) ? 1'b1 : cin;
         cnt_r   <= {CW{1'b0}};
         psum_r  <= {WIDTH{1'b0}};
      end else if (state_r == RUN) begin
         a_r     <= a_r >> DIGIT;
         b_r     <= b_r >> DIGIT;
         carry_r <= dcout_s;
         cnt_r   <= cnt_r + CW'(1);
         psum_r  <= psum_next_s;
         if (finish_s) begin
            sum_r  <= psum_next_s;
            cout_r <= dcout_s;
            ovf_r  <= dcout_s ^ dcmsb_s;
            zero_r <= (psum_next_s == {WIDTH{1'b0}});
         end
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign sum       = sum_r;
   assign cout      = cout_r;
   assign ovf       = ovf_r;
   assign zero      = zero_r;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// ----------------------------------------------------------------------------
// tb_serial_adder
// Three serial_adder instances (DIGIT = 4, 16 via DIGIT=1, and 1 via
// DIGIT=16) share one stimulus stream. Accepted operations are scored by an
// arithmetic reference model into per-instance queues; a monitor pops and
// compares whenever an instance presents a result.
// ----------------------------------------------------------------------------
module tb_serial_adder;

   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        cin;
   logic        sub;
   logic        out_ready;
   logic [15:0] a;
   logic [15:0] b;

   logic        in_ready_w  [NI];
   logic        out_valid_w [NI];
   logic        cout_w      [NI];
   logic        ovf_w       [NI];
   logic        zero_w      [NI];
   logic [15:0] sum_w       [NI];

   typedef struct packed {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
      int          due;
   } exp_t;

   exp_t exp_q [NI][$];
   bit   seen  [NI];
   int   cyc   = 0;
   int   tests = 0;
   int   fails = 0;
   bit   rand_bp = 1'b0;

   always #5 clk = ~clk;

   // Cycle counter: value k after the k-th rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int DG = (gi == 0) ? 4 : ((gi == 1) ? 1 : 16);
      serial_adder #(.WIDTH(16), .DIGIT(DG)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid),
         .in_ready  (in_ready_w[gi]),
         .a         (a),
         .b         (b),
         .cin       (cin),
         .sub       (sub),
         .out_valid (out_valid_w[gi]),
         .out_ready (out_ready),
         .sum       (sum_w[gi]),
         .cout      (cout_w[gi]),
         .ovf       (ovf_w[gi]),
         .zero      (zero_w[gi])
      );
   end

   function automatic int ndig(input int i);
      return (i == 0) ? 4 : ((i == 1) ? 16 : 1);
   endfunction

   // Reference: plain unsigned/signed integer arithmetic.
   function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                  input logic cv, input logic sv, input int due);
      exp_t        m;
      logic [16:0] u;
      int          sa;
      int          sb;
      int          r;
      sa = $signed(av);
      sb = $signed(bv);
      if (sv) begin
         u      = {1'b0, av} - {1'b0, bv};
         r      = sa - sb;
         m.cout = (av >= bv);
      end else begin
         u      = {1'b0, av} + {1'b0, bv} + {16'd0, cv};
         r      = sa + sb + (cv ? 1 : 0);
         m.cout = u[16];
      end
      m.sum  = u[15:0];
      m.ovf  = (r > 32767) || (r < -32768);
      m.zero = (u[15:0] == 16'h0000);
      m.due  = due;
      return m;
   endfunction

   task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h (cycle %0d)", nm, inst, act, expv, cyc);
      end
   endtask

   task automatic timeout_fail(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: wait bound expired at cycle %0d", nm, cyc);
   endtask

   function automatic bit all_ready();
      for (int i = 0; i < NI; i++) begin
         if (!in_ready_w[i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic bit all_empty();
      for (int i = 0; i < NI; i++) begin
         if (exp_q[i].size() != 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic cv, input logic sv);
      int n = 0;
      while (!all_ready() && n < 300) begin
         step();
         n++;
      end
      if (!all_ready()) timeout_fail("issue_wait");
      a        = av;
      b        = bv;
      cin      = cv;
      sub      = sv;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (!(all_ready() && all_empty()) && n < 400) begin
         step();
         n++;
      end
      if (!(all_ready() && all_empty())) timeout_fail("drain_wait");
   endtask

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 5))
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         2:       return 16'h8000;
         3:       return 16'h7FFF;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = 16'h0000;
      b         = 16'h0000;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;
      fork
         begin : stim
            int n;
            repeat (3) step();
            for (int i = 0; i < NI; i++) begin
               chk("rst_in_ready", i, 32'(in_ready_w[i]), 32'd1);
               chk("rst_out_valid", i, 32'(out_valid_w[i]), 32'd0);
               chk("rst_sum", i, 32'(sum_w[i]), 32'd0);
               chk("rst_flags", i, {29'd0, cout_w[i], ovf_w[i], zero_w[i]}, 32'd0);
            end
            rst_n = 1'b1;
            step();

            // Directed vectors (cin=1 on the subtracts must be ignored).
            issue(16'h1234, 16'h4321, 1'b0, 1'b0);
            issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
            issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
            issue(16'h0005, 16'h0007, 1'b1, 1'b1);
            issue(16'h8000, 16'h0001, 1'b1, 1'b1);
            drain();

            // Backpressure: result held, new operands refused while in DONE.
            out_ready = 1'b0;
            issue(16'h1111, 16'h2222, 1'b0, 1'b0);
            n = 0;
            while (!out_valid_w[0] && n < 50) begin
               step();
               n++;
            end
            if (!out_valid_w[0]) timeout_fail("bp_wait_valid");
            a        = 16'hAAAA;
            b        = 16'h5555;
            in_valid = 1'b1;
            repeat (3) begin
               step();
               chk("bp_in_ready", 0, 32'(in_ready_w[0]), 32'd0);
               chk("bp_out_valid", 0, 32'(out_valid_w[0]), 32'd1);
               chk("bp_sum_hold", 0, 32'(sum_w[0]), 32'h3333);
            end
            a         = 16'h0101;
            b         = 16'h0202;
            out_ready = 1'b1;
            step();
            chk("bp_back_idle", 0, {30'd0, in_ready_w[0], out_valid_w[0]}, 32'd2);
            step();
            in_valid = 1'b0;
            drain();

            // Reset in the second RUN cycle discards the operation.
            issue(16'h1234, 16'h0FF0, 1'b0, 1'b0);
            step();
            rst_n = 1'b0;
            step();
            for (int i = 0; i < NI; i++) begin
               chk("midrst_in_ready", i, 32'(in_ready_w[i]), 32'd1);
               chk("midrst_out_valid", i, 32'(out_valid_w[i]), 32'd0);
               chk("midrst_sum", i, 32'(sum_w[i]), 32'd0);
            end
            rst_n = 1'b1;
            repeat (20) step();
            issue(16'h0001, 16'h0001, 1'b0, 1'b0);
            drain();

            // Randomized operations with random result backpressure.
            rand_bp = 1'b1;
            repeat (40) issue(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            rand_bp   = 1'b0;
            out_ready = 1'b1;
            drain();
            repeat (3) step();
         end
         forever begin : monitor
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
               if (out_valid_w[i]) begin
                  if (exp_q[i].size() == 0) begin
                     timeout_fail($sformatf("spurious_out_valid inst%0d", i));
                  end else begin
                     if (!seen[i]) chk("latency", i, 32'(cyc), 32'(exp_q[i][0].due));
                     chk("sum", i, 32'(sum_w[i]), 32'(exp_q[i][0].sum));
                     chk("cout", i, 32'(cout_w[i]), 32'(exp_q[i][0].cout));
                     chk("ovf", i, 32'(ovf_w[i]), 32'(exp_q[i][0].ovf));
                     chk("zero", i, 32'(zero_w[i]), 32'(exp_q[i][0].zero));
                     seen[i] = 1'b1;
                     if (out_ready && rst_n) begin
                        void'(exp_q[i].pop_front());
                        seen[i] = 1'b0;
                     end
                  end
               end
            end
            if (!rst_n) begin
               for (int i = 0; i < NI; i++) begin
                  exp_q[i].delete();
                  seen[i] = 1'b0;
               end
            end else if (in_valid) begin
               for (int i = 0; i < NI; i++) begin
                  if (in_ready_w[i]) exp_q[i].push_back(model(a, b, cin, sub, cyc + 1 + ndig(i)));
               end
            end
         end
      join_any
      disable fork;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_serial_adder
